multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencer for the MIPS datapath. It replaces the single-cycle opcode decoder with a state machine that steps one shared ALU and one unified instruction/data memory through the phases of each instruction: fetch, decode, execute, memory and writeback. It sits between the instruction register and the datapath muxes and enables. It also owns a req/ready handshake to the unified memory.

## Interface
- Parameters: none.
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- opcode_i  in  6  IR[31:26], valid from DECODE onward
- zero_i  in  1  ALU zero flag, combinational from the current ALU operation
- mem_ready_i  in  1  memory completes the current request this cycle
- mem_req_o  out  1  memory access request
- mem_we_o  out  1  write qualifier for mem_req_o
- iord_o  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_write_o  out  1  load IR/MDR from memory read data
- pc_write_o  out  1  PC load enable (unconditional writes and taken branches)
- pc_src_o  out  2  PC source: 0 = ALU result, 1 = ALUOut, 2 = jump target
- alu_src_a_o  out  1  ALU A input: 0 = PC, 1 = rs
- alu_src_b_o  out  2  ALU B input: 0 = rt, 1 = constant 4, 2 = sign-extended imm, 3 = sign-extended imm << 2
- alu_op_o  out  3  ALU operation code: 111 = R-type funct, 100 = add-imm, 101 = or, 110 = lui, 011 = add, 001 = sub
- reg_write_o  out  1  register file write enable
- reg_dst_o  out  2  write register select: 0 = rt, 1 = rd, 2 = $31
- mem_to_reg_o  out  2  write data select: 0 = ALUOut, 1 = MDR, 2 = PC
- instr_done_o  out  1  one-cycle pulse on the last cycle of each instruction
- illegal_o  out  1  sticky flag: unsupported opcode decoded

## Operation
- FETCH: mem_req=1, iord=0, src_a=0, src_b=1, alu_op=011.
  - ir_write and pc_write (pc_src=0) assert only in the cycle where mem_ready_i=1.
  - Go to DECODE on mem_ready_i; otherwise stay in FETCH.
- DECODE: src_a=0, src_b=3, alu_op=011, computing the branch target into ALUOut. Dispatch on opcode:
  - 0x00 → EXEC_R
  - 0x08, 0x0d, 0x0f → EXEC_I
  - 0x23, 0x2b → MEM_ADDR
  - 0x04, 0x05 → BRANCH
  - 0x02, 0x03 → JUMP
  - any other opcode → HALT
- EXEC_R: src_a=1, src_b=0, alu_op=111 → ALU_WB with reg_dst=1.
- EXEC_I: src_a=1, src_b=2, alu_op set by opcode (addi 100, ori 101, lui 110) → ALU_WB with reg_dst=0.
- ALU_WB: reg_write=1, mem_to_reg=0, instr_done=1 → FETCH.
- MEM_ADDR: src_a=1, src_b=2, alu_op=011. Next state is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_req=1, iord=1, ir_write=0 (MDR loads every cycle). On mem_ready_i → MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1 → FETCH.
- MEM_WR: mem_req=1, mem_we=1, iord=1. On mem_ready_i: instr_done=1 → FETCH.
- BRANCH: src_a=1, src_b=0, alu_op=001, pc_src=1.
  - pc_write = zero_i for beq, !zero_i for bne.
  - instr_done=1 → FETCH.
- JUMP: pc_write=1, pc_src=2, instr_done=1 → FETCH. Link behaviour for jal: see Configuration.
- HALT: all outputs 0 except illegal_o=1. Exits only via reset.
- Output types:
  - pc_write, ir_write and instr_done in memory states are Mealy (they depend on mem_ready_i / zero_i).
  - All other outputs are Moore, decoded from state and the latched opcode.
- The opcode is latched into an internal register on the DECODE cycle, so IR changes later in the instruction have no effect.

## Timing
- Reset: state=FETCH on the next edge; internal opcode register cleared to 0.
  - All outputs read 0 during and after the reset cycle, except the FETCH Moore outputs once reset deasserts.
  - illegal_o clears on reset.
- Reset mid-access drops the request: mem_req_o is low in the cycle after the reset edge that samples reset=1. No write completes after reset.
- With zero-wait memory (mem_ready_i tied to 1), cycles per instruction are:
  - R-type and I-type ALU: 4
  - lw: 5
  - sw: 4
  - beq/bne: 3
  - j/jal: 3
- Each memory wait cycle adds exactly one cycle. During a wait, request outputs are held stable.
- mem_ready_i is ignored outside FETCH, MEM_RD and MEM_WR.

## Configuration
- Macro JAL_LINK_EN.
  - Defined: in JUMP, when the latched opcode is 0x03, also drive reg_write=1, reg_dst=2, mem_to_reg=2. This writes PC+4 (already in PC) to $31.
  - Undefined: jal behaves exactly like j, and reg_dst/mem_to_reg never take value 2.

## Structure
- Package mips_ctrl_pkg holds:
  - the state enum (FETCH…HALT)
  - opcode constants
  - alu_op codes
  - the pc_src, alu_src_b, reg_dst and mem_to_reg select encodings
- One sub-module, multicycle_ctrl_decode: purely combinational; maps state, opcode, zero_i and mem_ready_i to all outputs.
- The top level contains only the state register, the opcode latch and the next-state logic.

## Test plan
- Reset held 2 cycles then released, with mem_ready=1 → illegal_o=0, mem_req_o=1 in the first post-reset cycle, state FETCH.
- add (opcode 0x00), ready=1 → reg_write pulses in cycle 4 with reg_dst=1; instr_done in cycle 4; next FETCH in cycle 5.
- lw (0x23) with ready low for 2 cycles in MEM_RD → 7 cycles total; iord=1 held through the waits; reg_write with mem_to_reg=1 once.
- Branch pair:
  - beq (0x04) with zero_i=1 → pc_write=1, pc_src=1 in cycle 3.
  - bne (0x05) with zero_i=1 → pc_write=0.
- jal (0x03):
  - With JAL_LINK_EN → reg_write=1, reg_dst=2, mem_to_reg=2, pc_src=2 in cycle 3.
  - Without the macro → reg_write=0.
- Opcode 0x3f → HALT, illegal_o=1, no mem_req for 10 cycles; reset asserted in the middle of a stalled sw → mem_we_o=0 and FETCH after release.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS sequencer: FSM states,
// opcodes, ALU operation codes and the datapath mux select encodings.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    EXEC_R,
    EXEC_I,
    ALU_WB,
    MEM_ADDR,
    MEM_RD,
    MEM_WB,
    MEM_WR,
    BRANCH,
    JUMP,
    HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b011;
  localparam logic [2:0] ALU_ADDI  = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_LUI   = 3'b110;
  localparam logic [2:0] ALU_FUNCT = 3'b111;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic [1:0] B_RT      = 2'd0;
  localparam logic [1:0] B_FOUR    = 2'd1;
  localparam logic [1:0] B_IMM     = 2'd2;
  localparam logic [1:0] B_IMM_SH2 = 2'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  // First execution state for a freshly decoded opcode; unknown opcodes park in HALT.
  function automatic state_t dispatch(input logic [5:0] op);
    case (op)
      OP_RTYPE:              return EXEC_R;
      OP_ADDI, OP_ORI, OP_LUI: return EXEC_I;
      OP_LW, OP_SW:          return MEM_ADDR;
      OP_BEQ, OP_BNE:        return BRANCH;
      OP_J, OP_JAL:          return JUMP;
      default:               return HALT;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational output decoder for the multi-cycle sequencer: maps the current
// state, latched opcode, zero flag and memory ready to every datapath control.
module multicycle_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic       reset,
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       iord_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic [1:0] pc_src_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_op_o,
  output logic       reg_write_o,
  output logic [1:0] reg_dst_o,
  output logic [1:0] mem_to_reg_o,
  output logic       instr_done_o,
  output logic       illegal_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    iord_o       = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    pc_src_o     = PC_SRC_ALU;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = B_RT;
    alu_op_o     = 3'b000;
    reg_write_o  = 1'b0;
    reg_dst_o    = DST_RT;
    mem_to_reg_o = WB_ALUOUT;
    instr_done_o = 1'b0;
    illegal_o    = 1'b0;

    // While reset is held every control is forced low, so an in-flight access is dropped.
    if (!reset) begin
      case (state)
        FETCH: begin
          mem_req_o   = 1'b1;
          alu_src_b_o = B_FOUR;
          alu_op_o    = ALU_ADD;
          ir_write_o  = mem_ready_i;
          pc_write_o  = mem_ready_i;
        end
        DECODE: begin
          alu_src_b_o = B_IMM_SH2;
          alu_op_o    = ALU_ADD;
        end
        EXEC_R: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = B_RT;
          alu_op_o    = ALU_FUNCT;
        end
        EXEC_I: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = B_IMM;
          case (opcode)
            OP_ADDI: alu_op_o = ALU_ADDI;
            OP_ORI:  alu_op_o = ALU_OR;
            default: alu_op_o = ALU_LUI;
          endcase
        end
        ALU_WB: begin
          reg_write_o  = 1'b1;
          reg_dst_o    = (opcode == OP_RTYPE) ? DST_RD : DST_RT;
          instr_done_o = 1'b1;
        end
        MEM_ADDR: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = B_IMM;
          alu_op_o    = ALU_ADD;
        end
        MEM_RD: begin
          mem_req_o = 1'b1;
          iord_o    = 1'b1;
        end
        MEM_WB: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = WB_MDR;
          instr_done_o = 1'b1;
        end
        MEM_WR: begin
          mem_req_o    = 1'b1;
          mem_we_o     = 1'b1;
          iord_o       = 1'b1;
          instr_done_o = mem_ready_i;
        end
        BRANCH: begin
          alu_src_a_o  = 1'b1;
          alu_src_b_o  = B_RT;
          alu_op_o     = ALU_SUB;
          pc_src_o     = PC_SRC_ALUOUT;
          pc_write_o   = (opcode == OP_BNE) ? !zero_i : zero_i;
          instr_done_o = 1'b1;
        end
        JUMP: begin
          pc_write_o   = 1'b1;
          pc_src_o     = PC_SRC_JUMP;
          instr_done_o = 1'b1;
`ifdef JAL_LINK_EN
          // PC already holds PC+4, so the link value is taken straight from it.
          if (opcode == OP_JAL) begin
            reg_write_o  = 1'b1;
            reg_dst_o    = DST_RA;
            mem_to_reg_o = WB_PC;
          end
`endif
        end
        HALT: illegal_o = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: state register, opcode latch and next-state logic.
// Optional macro JAL_LINK_EN makes jal write PC+4 to $31.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       iord_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic [1:0] pc_src_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_op_o,
  output logic       reg_write_o,
  output logic [1:0] reg_dst_o,
  output logic [1:0] mem_to_reg_o,
  output logic       instr_done_o,
  output logic       illegal_o
);

  state_t     state;
  logic [5:0] opcode_q;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      opcode_q <= '0;
    end else begin
      case (state)
        FETCH:    if (mem_ready_i) state <= DECODE;
        DECODE: begin
          // Later IR changes must not affect the instruction in flight.
          opcode_q <= opcode_i;
          state    <= dispatch(opcode_i);
        end
        EXEC_R,
        EXEC_I:   state <= ALU_WB;
        MEM_ADDR: state <= (opcode_q == OP_LW) ? MEM_RD : MEM_WR;
        MEM_RD:   if (mem_ready_i) state <= MEM_WB;
        MEM_WR:   if (mem_ready_i) state <= FETCH;
        ALU_WB,
        MEM_WB,
        BRANCH,
        JUMP:     state <= FETCH;
        HALT:     state <= HALT;
        default:  state <= HALT;
      endcase
    end
  end

  multicycle_ctrl_decode u_decode (
    .reset        (reset),
    .state        (state),
    .opcode       (opcode_q),
    .zero_i       (zero_i),
    .mem_ready_i  (mem_ready_i),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .iord_o       (iord_o),
    .ir_write_o   (ir_write_o),
    .pc_write_o   (pc_write_o),
    .pc_src_o     (pc_src_o),
    .alu_src_a_o  (alu_src_a_o),
    .alu_src_b_o  (alu_src_b_o),
    .alu_op_o     (alu_op_o),
    .reg_write_o  (reg_write_o),
    .reg_dst_o    (reg_dst_o),
    .mem_to_reg_o (mem_to_reg_o),
    .instr_done_o (instr_done_o),
    .illegal_o    (illegal_o)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed table, hand-written
// corner sequences and randomized instructions against a per-instruction model.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode_i = '0;
  logic       zero_i = 1'b0;
  logic       mem_ready_i = 1'b0;
  logic       mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o;
  logic [1:0] pc_src_o, alu_src_b_o, reg_dst_o, mem_to_reg_o;
  logic       alu_src_a_o, reg_write_o, instr_done_o, illegal_o;
  logic [2:0] alu_op_o;
  logic [19:0] all_out;

  multicycle_control dut (
    .clk          (clk),
    .reset        (reset),
    .opcode_i     (opcode_i),
    .zero_i       (zero_i),
    .mem_ready_i  (mem_ready_i),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .iord_o       (iord_o),
    .ir_write_o   (ir_write_o),
    .pc_write_o   (pc_write_o),
    .pc_src_o     (pc_src_o),
    .alu_src_a_o  (alu_src_a_o),
    .alu_src_b_o  (alu_src_b_o),
    .alu_op_o     (alu_op_o),
    .reg_write_o  (reg_write_o),
    .reg_dst_o    (reg_dst_o),
    .mem_to_reg_o (mem_to_reg_o),
    .instr_done_o (instr_done_o),
    .illegal_o    (illegal_o)
  );

  assign all_out = {mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_src_o,
                    alu_src_a_o, alu_src_b_o, alu_op_o, reg_write_o, reg_dst_o,
                    mem_to_reg_o, instr_done_o, illegal_o};

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Per-instruction observations; -1 marks "never seen".
  typedef struct {
    int cycles; int rw; int dst; int m2r; int pcw; int pcsrc;
    int req; int we; int iord; int irw; int alu; int done;
  } stats_t;

  typedef struct {
    logic [5:0] op; bit zero; int fw; int mw;
    int cycles; int rw; int dst; int m2r; int pcw; int pcsrc; int alu;
  } vec_t;

  logic [5:0] legal_ops [10] = '{6'h00, 6'h08, 6'h0d, 6'h0f, 6'h23,
                                 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03};

  // Expected totals for one instruction, from the instruction class, the branch
  // outcome and the number of memory wait cycles on fetch (fw) and data (mw).
  function automatic stats_t ref_model(input logic [5:0] op, input bit zero,
                                       input int fw, input int mw);
    stats_t e;
    e = '{default: 0};
    e.dst = -1; e.m2r = -1; e.alu = -1;
    e.req = 1 + fw; e.pcw = 1; e.irw = 1; e.done = 1;
    case (op)
      6'h00: begin e.cycles = 4 + fw; e.rw = 1; e.dst = 1; e.m2r = 0; e.alu = 7; end
      6'h08, 6'h0d, 6'h0f: begin
        e.cycles = 4 + fw; e.rw = 1; e.dst = 0; e.m2r = 0;
        e.alu = (op == 6'h08) ? 4 : (op == 6'h0d) ? 5 : 6;
      end
      6'h23: begin
        e.cycles = 5 + fw + mw; e.rw = 1; e.dst = 0; e.m2r = 1; e.alu = 3;
        e.req += 1 + mw; e.iord = 1 + mw;
      end
      6'h2b: begin
        e.cycles = 4 + fw + mw; e.alu = 3;
        e.req += 1 + mw; e.we = 1 + mw; e.iord = 1 + mw;
      end
      6'h04, 6'h05: begin
        e.cycles = 3 + fw; e.alu = 1;
        if ((op == 6'h04) == zero) begin e.pcw = 2; e.pcsrc = 1; end
      end
      default: begin
        e.cycles = 3 + fw; e.pcw = 2; e.pcsrc = 2;
`ifdef JAL_LINK_EN
        if (op == 6'h03) begin e.rw = 1; e.dst = 2; e.m2r = 2; end
`endif
      end
    endcase
    return e;
  endfunction

  // Runs one instruction from FETCH (called at posedge+1) until instr_done or budget.
  // The memory model answers requests after the given number of wait cycles.
  task automatic run_instr(input logic [5:0] op, input bit zero, input int fw,
                           input int mw, output stats_t s);
    int waited = 0;
    int accesses = 0;
    int cyc = 0;
    s = '{default: 0};
    s.dst = -1; s.m2r = -1; s.alu = -1;
    while (cyc < 30 && s.done == 0) begin
      zero_i   = zero;
      opcode_i = (cyc <= fw + 1) ? op : 6'($urandom);
      if (mem_req_o) begin
        if (waited < ((accesses == 0) ? fw : mw)) begin
          mem_ready_i = 1'b0; waited++;
        end else begin
          mem_ready_i = 1'b1; waited = 0; accesses++;
        end
      end else begin
        mem_ready_i = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
      if (reg_write_o) begin s.rw++; s.dst = int'(reg_dst_o); s.m2r = int'(mem_to_reg_o); end
      if (pc_write_o) begin s.pcw++; s.pcsrc = int'(pc_src_o); end
      if (mem_req_o) s.req++;
      if (mem_we_o) s.we++;
      if (iord_o) s.iord++;
      if (ir_write_o) s.irw++;
      if (alu_src_a_o) s.alu = int'(alu_op_o);
      if (instr_done_o) s.done = 1;
      @(posedge clk); #1;
    end
    s.cycles = cyc;
  endtask

  task automatic cmp_stats(input string tag, input stats_t s, input stats_t e);
    check({tag, " cycles"}, s.cycles, e.cycles);
    check({tag, " reg_write count"}, s.rw, e.rw);
    check({tag, " reg_dst"}, s.dst, e.dst);
    check({tag, " mem_to_reg"}, s.m2r, e.m2r);
    check({tag, " pc_write count"}, s.pcw, e.pcw);
    check({tag, " pc_src"}, s.pcsrc, e.pcsrc);
    check({tag, " mem_req cycles"}, s.req, e.req);
    check({tag, " mem_we cycles"}, s.we, e.we);
    check({tag, " iord cycles"}, s.iord, e.iord);
    check({tag, " ir_write count"}, s.irw, e.irw);
    check({tag, " exec alu_op"}, s.alu, e.alu);
    check({tag, " done"}, s.done, e.done);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    vec_t   vecs [15];
    stats_t s;
    stats_t e;
    int     halt_req;
    int     halt_ill;
    int     halt_other;

    vecs[0]  = '{6'h00, 1'b0, 0, 0, 4, 1, 1, 0, 1, 0, 7};
    vecs[1]  = '{6'h08, 1'b0, 0, 0, 4, 1, 0, 0, 1, 0, 4};
    vecs[2]  = '{6'h0d, 1'b1, 0, 0, 4, 1, 0, 0, 1, 0, 5};
    vecs[3]  = '{6'h0f, 1'b0, 1, 0, 5, 1, 0, 0, 1, 0, 6};
    vecs[4]  = '{6'h23, 1'b0, 0, 0, 5, 1, 0, 1, 1, 0, 3};
    vecs[5]  = '{6'h23, 1'b0, 0, 2, 7, 1, 0, 1, 1, 0, 3};
    vecs[6]  = '{6'h2b, 1'b0, 0, 0, 4, 0, -1, -1, 1, 0, 3};
    vecs[7]  = '{6'h2b, 1'b1, 1, 1, 6, 0, -1, -1, 1, 0, 3};
    vecs[8]  = '{6'h04, 1'b1, 0, 0, 3, 0, -1, -1, 2, 1, 1};
    vecs[9]  = '{6'h04, 1'b0, 0, 0, 3, 0, -1, -1, 1, 0, 1};
    vecs[10] = '{6'h05, 1'b1, 0, 0, 3, 0, -1, -1, 1, 0, 1};
    vecs[11] = '{6'h05, 1'b0, 0, 0, 3, 0, -1, -1, 2, 1, 1};
    vecs[12] = '{6'h02, 1'b0, 0, 0, 3, 0, -1, -1, 2, 2, -1};
`ifdef JAL_LINK_EN
    vecs[13] = '{6'h03, 1'b0, 0, 0, 3, 1, 2, 2, 2, 2, -1};
`else
    vecs[13] = '{6'h03, 1'b0, 0, 0, 3, 0, -1, -1, 2, 2, -1};
`endif
    vecs[14] = '{6'h00, 1'b1, 2, 0, 6, 1, 1, 0, 1, 0, 7};

    // Reset held two cycles with ready high, then an add cycle by cycle.
    reset = 1'b1; mem_ready_i = 1'b1; opcode_i = 6'h00; zero_i = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset all outputs", all_out, 20'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      mem_ready_i = (c == 5) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (c == 1) begin
        check("post-reset mem_req", mem_req_o, 1);
        check("post-reset illegal", illegal_o, 0);
        check("post-reset ir_write", ir_write_o, 1);
        check("post-reset alu_src_b", alu_src_b_o, 1);
        check("post-reset alu_op", alu_op_o, 3);
      end
      check($sformatf("add c%0d reg_write", c), reg_write_o, c == 4);
      check($sformatf("add c%0d instr_done", c), instr_done_o, c == 4);
      if (c == 4) check("add c4 reg_dst", reg_dst_o, 1);
      if (c == 5) begin
        check("add c5 mem_req", mem_req_o, 1);
        check("add c5 ir_write while not ready", ir_write_o, 0);
      end
      @(posedge clk); #1;
    end

    // Directed table.
    for (int i = 0; i < 15; i++) begin
      run_instr(vecs[i].op, vecs[i].zero, vecs[i].fw, vecs[i].mw, s);
      check($sformatf("vec%0d cycles", i), s.cycles, vecs[i].cycles);
      check($sformatf("vec%0d reg_write count", i), s.rw, vecs[i].rw);
      check($sformatf("vec%0d reg_dst", i), s.dst, vecs[i].dst);
      check($sformatf("vec%0d mem_to_reg", i), s.m2r, vecs[i].m2r);
      check($sformatf("vec%0d pc_write count", i), s.pcw, vecs[i].pcw);
      check($sformatf("vec%0d pc_src", i), s.pcsrc, vecs[i].pcsrc);
      check($sformatf("vec%0d exec alu_op", i), s.alu, vecs[i].alu);
      check($sformatf("vec%0d done", i), s.done, 1);
    end

    // Illegal opcode parks in HALT until reset.
    opcode_i = 6'h3f; mem_ready_i = 1'b1;
    @(negedge clk); @(posedge clk); #1;
    @(negedge clk); @(posedge clk); #1;
    halt_req = 0; halt_ill = 0; halt_other = 0;
    for (int c = 0; c < 10; c++) begin
      mem_ready_i = 1'($urandom);
      opcode_i = 6'($urandom);
      @(negedge clk);
      if (mem_req_o) halt_req++;
      if (illegal_o) halt_ill++;
      if (all_out[19:1] != '0) halt_other++;
      @(posedge clk); #1;
    end
    check("halt mem_req cycles", halt_req, 0);
    check("halt illegal cycles", halt_ill, 10);
    check("halt other outputs active", halt_other, 0);
    reset = 1'b1;
    @(negedge clk);
    check("halt reset illegal", illegal_o, 0);
    @(posedge clk); #1;
    reset = 1'b0; mem_ready_i = 1'b0;
    @(negedge clk);
    check("after halt reset illegal", illegal_o, 0);
    check("after halt reset mem_req", mem_req_o, 1);
    @(posedge clk); #1;

    // sw stalled in MEM_WR, then reset mid-access.
    opcode_i = 6'h2b; mem_ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); @(posedge clk); #1;
    end
    mem_ready_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("sw wait%0d mem_we", c), mem_we_o, 1);
      check($sformatf("sw wait%0d iord", c), iord_o, 1);
      check($sformatf("sw wait%0d instr_done", c), instr_done_o, 0);
      @(posedge clk); #1;
    end
    reset = 1'b1; mem_ready_i = 1'b1;
    @(negedge clk);
    check("sw reset mem_we", mem_we_o, 0);
    check("sw reset mem_req", mem_req_o, 0);
    check("sw reset instr_done", instr_done_o, 0);
    @(posedge clk); #1;
    reset = 1'b0; mem_ready_i = 1'b0;
    @(negedge clk);
    check("sw after reset mem_req", mem_req_o, 1);
    check("sw after reset mem_we", mem_we_o, 0);
    check("sw after reset iord", iord_o, 0);
    check("sw after reset alu_src_b", alu_src_b_o, 1);
    @(posedge clk); #1;

    // Randomized instructions against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [5:0] op;
      bit         zero;
      int         fw;
      int         mw;
      op   = legal_ops[$urandom_range(0, 9)];
      zero = 1'($urandom);
      fw   = $urandom_range(0, 2);
      mw   = $urandom_range(0, 3);
      e = ref_model(op, zero, fw, mw);
      run_instr(op, zero, fw, mw, s);
      cmp_stats($sformatf("rnd%0d op%0h", i, op), s, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
